// File: rtl/fifo_axis_frame_tx.sv
// Drains a show-ahead FIFO into framed AXI-Stream beats of a programmable length.
// One output register gives one beat per cycle while m_tready stays high.
module fifo_axis_frame_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] sent;
    logic                 xfer;

    assign xfer = m_tvalid & m_tready;

    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (frame_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // A pop may only refill the output register if it is empty or draining now.
                fifo_rd_en = !fifo_empty && (issued != len_q) && (!m_tvalid || m_tready);
                if (xfer && m_tlast) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            issued    <= '0;
            sent      <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start && frame_len != '0) begin
                len_q  <= frame_len;
                issued <= '0;
                sent   <= '0;
            end
            // Pop and drain in the same cycle simply reloads the register.
            if (fifo_rd_en) begin
                m_tdata  <= fifo_data;
                m_tvalid <= 1'b1;
                m_tlast  <= (issued == len_q - LEN_ONE);
                issued   <= issued + LEN_ONE;
            end else if (xfer) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end
            if (xfer) begin
                sent <= sent + LEN_ONE;
            end
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fifo_axis_frame_tx.sv
// Randomized bench for fifo_axis_frame_tx: a queue-based FIFO and a frame-level
// reference model predict every output each cycle.
module tb_fifo_axis_frame_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] frame_len;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    fifo_axis_frame_tx #(
        .DATA_WIDTH(32),
        .LEN_WIDTH (16),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Environment FIFO and reference model state
    logic [31:0] fifo_q[$];
    logic [31:0] inflight[$];
    bit          frameActive;
    bit          doneCycle;
    int          curLen;
    int          issuedM;
    int          beatIdx;
    logic [15:0] expCnt;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic updateFifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    endtask

    task automatic pushWord(input logic [31:0] w);
        fifo_q.push_back(w);
        updateFifo();
    endtask

    task automatic resetModel();
        inflight.delete();
        frameActive = 1'b0;
        doneCycle   = 1'b0;
        curLen      = 0;
        issuedM     = 0;
        beatIdx     = 0;
        expCnt      = '0;
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance both.
    task automatic applyStimulus(input bit st, input int len, input bit rdy, input bit rs);
        bit expValid, expRd, xfer, accept, newDone, lastBeat, popNow;
        logic [31:0] head;
        start     = st;
        frame_len = 16'(len);
        m_tready  = rdy;
        rst       = rs;
        @(negedge clk);
        expValid = (inflight.size() != 0);
        expRd    = frameActive && (fifo_q.size() != 0) && (issuedM != curLen) && (!expValid || rdy);
        checkOutput("tvalid", {31'b0, m_tvalid}, {31'b0, expValid});
        checkOutput("rd_en", {31'b0, fifo_rd_en}, {31'b0, expRd});
        checkOutput("busy", {31'b0, busy}, {31'b0, frameActive});
        checkOutput("done", {31'b0, done}, {31'b0, doneCycle});
        checkOutput("frame_cnt", {16'b0, frame_cnt}, {16'b0, expCnt});
        if (expValid) begin
            checkOutput("tdata", m_tdata, inflight[0]);
            checkOutput("tlast", {31'b0, m_tlast}, {31'b0, (beatIdx == curLen - 1)});
        end
        popNow = fifo_rd_en && !fifo_empty;
        head   = fifo_data;
        xfer   = expValid && rdy;
        accept = st && !frameActive;
        if (rs) begin
            resetModel();
        end else begin
            newDone = 1'b0;
            if (doneCycle) begin
                frameActive = 1'b0;
                expCnt      = expCnt + 16'd1;
            end
            if (xfer) begin
                lastBeat = (beatIdx == curLen - 1);
                void'(inflight.pop_front());
                beatIdx++;
                if (lastBeat) newDone = 1'b1;
            end
            if (expRd) begin
                inflight.push_back(head);
                issuedM++;
            end
            if (accept) begin
                curLen      = len;
                issuedM     = 0;
                beatIdx     = 0;
                frameActive = 1'b1;
                if (len == 0) newDone = 1'b1;
            end
            doneCycle = newDone;
        end
        @(posedge clk);
        #1;
        if (popNow) void'(fifo_q.pop_front());
        updateFifo();
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, rdy, 1'b0);
    endtask

    initial begin
        int budget;
        rst       = 1'b1;
        start     = 1'b0;
        frame_len = '0;
        m_tready  = 1'b0;
        updateFifo();
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic 4-word frame under continuous ready
        pushWord(32'h11); pushWord(32'h22); pushWord(32'h33); pushWord(32'h44);
        applyStimulus(1'b1, 4, 1'b1, 1'b0);
        idleCycles(8, 1'b1);

        // Stalling sink: ready pattern 1,0,0 repeating
        pushWord(32'h11); pushWord(32'h22); pushWord(32'h33); pushWord(32'h44);
        applyStimulus(1'b1, 4, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 0, (i % 3) == 0, 1'b0);

        // FIFO runs dry mid-frame, refilled later
        pushWord(32'hA1);
        applyStimulus(1'b1, 3, 1'b1, 1'b0);
        idleCycles(5, 1'b1);
        pushWord(32'hA2); pushWord(32'hA3);
        idleCycles(6, 1'b1);

        // Zero-length frame
        applyStimulus(1'b1, 0, 1'b1, 1'b0);
        idleCycles(4, 1'b1);

        // Start during a running frame is ignored; then back-to-back length-2 frames
        pushWord(32'hB1); pushWord(32'hB2); pushWord(32'hB3); pushWord(32'hB4);
        applyStimulus(1'b1, 2, 1'b1, 1'b0);
        applyStimulus(1'b1, 2, 1'b1, 1'b0);
        idleCycles(4, 1'b1);
        applyStimulus(1'b1, 2, 1'b1, 1'b0);
        idleCycles(5, 1'b1);

        // Reset after two beats, then stream the leftovers
        pushWord(32'hC1); pushWord(32'hC2); pushWord(32'hC3); pushWord(32'hC4);
        applyStimulus(1'b1, 4, 1'b1, 1'b0);
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b1, 2, 1'b1, 1'b0);
        idleCycles(5, 1'b1);

        // Randomized traffic with occasional resets and spurious starts
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) pushWord($urandom);
            applyStimulus($urandom_range(0, 5) == 0, int'($urandom_range(0, 6)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        // Drain whatever frame is still open, bounded
        budget = 0;
        while ((frameActive || inflight.size() != 0) && budget < 2000) begin
            if (fifo_q.size() == 0) pushWord($urandom);
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            budget++;
        end
        checkOutput("drain_timeout", {31'b0, (budget >= 2000)}, 32'd0);
        idleCycles(3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
